seq_divider: RTL and testbench



---
 rtl/seq_divider.sv | 156 +++++++++++++++
 tb/tb_seq_divider.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// seq_divider: iterative radix-2 restoring divider, one quotient bit per cycle.
// Operands arrive on a valid/ready handshake. Quotient and remainder leave on a
// second valid/ready handshake. Only one operation is in flight at a time.
//
// Optional build macro: SEQ_DIVIDER_SIGNED_EN
//   Defined   : operands and results are two's complement. The quotient
//               truncates toward zero, and the remainder takes the dividend's sign.
//   Undefined : everything is unsigned and the sign logic is not built.
// A zero divisor gives quotient=all-ones, remainder=raw dividend and
// div_by_zero=1 in both modes.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state, state_next;

  logic                    accept;
  logic                    last_iter;
  logic                    zero_div;
  logic [WIDTH-1:0]        rem_acc;
  logic [WIDTH-1:0]        quo_acc;
  logic [WIDTH-1:0]        dvsr;
  logic [CNT_W-1:0]        cnt;
  logic [WIDTH:0]          rem_shift;
  logic signed [WIDTH:0]   trial;
  logic [WIDTH-1:0]        rem_next;
  logic [WIDTH-1:0]        quo_next;
  logic [WIDTH-1:0]        mag_dividend;
  logic [WIDTH-1:0]        mag_divisor;
  logic [WIDTH-1:0]        quo_final;
  logic [WIDTH-1:0]        rem_final;

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic neg_quo;
  logic neg_rem;

  // Absolute value. The most negative input maps to 2^(WIDTH-1), which still
  // fits as an unsigned magnitude.
  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
    logic signed [WIDTH-1:0] n;
    n = -v;
    return v[WIDTH-1] ? WIDTH'(n) : WIDTH'(v);
  endfunction

  // Conditional two's-complement negation used for the sign fix-up.
  function automatic logic [WIDTH-1:0] negate_if(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + WIDTH'(1)) : v;
  endfunction
`endif

  assign accept    = in_valid & in_ready;
  assign last_iter = (state == CALC) && (zero_div || (cnt == '0));

  // One restoring step: shift {R,Q} left and subtract the divisor on a trial basis.
  always_comb begin
    rem_shift = {rem_acc, quo_acc[WIDTH-1]};
    trial     = $signed(rem_shift - {1'b0, dvsr});
    quo_next  = {quo_acc[WIDTH-2:0], ~trial[WIDTH]};
    rem_next  = trial[WIDTH] ? rem_shift[WIDTH-1:0] : trial[WIDTH-1:0];
  end

  // Operand conditioning at accept and result sign fix-up at DONE entry.
  always_comb begin
`ifdef SEQ_DIVIDER_SIGNED_EN
    mag_dividend = magnitude(dividend);
    mag_divisor  = magnitude(divisor);
    quo_final    = negate_if(quo_next, neg_quo);
    rem_final    = negate_if(rem_next, neg_rem);
`else
    mag_dividend = dividend;
    mag_divisor  = divisor;
    quo_final    = quo_next;
    rem_final    = rem_next;
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept)                 state_next = CALC;
      CALC:    if (last_iter)              state_next = DONE;
      DONE:    if (out_valid && out_ready) state_next = IDLE;
      default:                             state_next = IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Working registers. They are loaded at accept before use, so they have no reset.
  // A zero divisor keeps the raw dividend in the Q register for the remainder output.
  // That case then spends exactly one cycle in CALC, which gives the one-cycle latency.
  always_ff @(posedge clk) begin
    if (accept) begin
      rem_acc  <= '0;
      quo_acc  <= (divisor == '0) ? dividend : mag_dividend;
      dvsr     <= mag_divisor;
      cnt      <= CNT_W'(WIDTH - 1);
      zero_div <= (divisor == '0);
`ifdef SEQ_DIVIDER_SIGNED_EN
      neg_quo  <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      neg_rem  <= dividend[WIDTH-1];
`endif
    end else if (state == CALC) begin
      rem_acc  <= rem_next;
      quo_acc  <= quo_next;
      cnt      <= cnt - CNT_W'(1);
    end
  end

  // Result registers. They change only on the edge that enters DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (last_iter) begin
      if (zero_div) begin
        quotient    <= '1;
        remainder   <= quo_acc;
        div_by_zero <= 1'b1;
      end else begin
        quotient    <= quo_final;
        remainder   <= rem_final;
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed testbench for seq_divider (WIDTH=8). Signed vectors are included
// when SEQ_DIVIDER_SIGNED_EN is defined.
module tb_seq_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int vectors = 0;
  int miscompares = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
    .out_ready(out_ready), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Stimulus only: present one operand pair, then wait (bounded) for out_valid.
  // lat counts the edges after the accept edge.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output logic [W-1:0] q_o,
                        output logic [W-1:0] r_o, output logic z_o);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    q_o = quotient;
    r_o = remainder;
    z_o = div_by_zero;
  endtask

  // Stimulus only: accept the result with a single-cycle out_ready pulse.
  task automatic take_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_handshake: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
    end
    vectors++;
    if (quotient !== 8'h00 || remainder !== 8'h00 || div_by_zero !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: q=%h r=%h z=%b, required 00 00 0", quotient, remainder, div_by_zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int lat; logic [W-1:0] q, r; logic z;
    run_op(8'd100, 8'd7, lat, q, r, z);
    vectors++;
    if (lat !== 8) begin
      miscompares++;
      $display("FAIL basic_latency: got %0d cycles, required 8", lat);
    end
    vectors++;
    if (q !== 8'd14 || r !== 8'd2 || z !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_100_7: q=%0d r=%0d z=%b, required 14 2 0", q, r, z);
    end
    take_result();
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || quotient !== 8'd14 || remainder !== 8'd2) begin
      miscompares++;
      $display("FAIL basic_release: out_valid=%b in_ready=%b q=%0d r=%0d, required 0 1 14 2",
               out_valid, in_ready, quotient, remainder);
    end
  endtask

  task automatic test_vectors();
    logic [W-1:0] va [3] = '{8'd255, 8'd3,   8'd200};
    logic [W-1:0] vb [3] = '{8'd1,   8'd200, 8'd200};
    logic [W-1:0] eq [3] = '{8'd255, 8'd0,   8'd1};
    logic [W-1:0] er [3] = '{8'd0,   8'd3,   8'd0};
    for (int i = 0; i < 3; i++) begin
      int lat; logic [W-1:0] q, r; logic z;
      run_op(va[i], vb[i], lat, q, r, z);
      vectors++;
      if (q !== eq[i] || r !== er[i] || z !== 1'b0 || lat !== 8) begin
        miscompares++;
        $display("FAIL vector_%0d_%0d: q=%0d r=%0d z=%b lat=%0d, required %0d %0d 0 8",
                 va[i], vb[i], q, r, z, lat, eq[i], er[i]);
      end
      take_result();
    end
  endtask

  task automatic test_div_zero();
    int lat; logic [W-1:0] q, r; logic z;
    run_op(8'd5, 8'd0, lat, q, r, z);
    vectors++;
    if (lat !== 1) begin
      miscompares++;
      $display("FAIL dbz_latency: got %0d cycles, required 1", lat);
    end
    vectors++;
    if (q !== 8'hFF || r !== 8'd5 || z !== 1'b1) begin
      miscompares++;
      $display("FAIL dbz_5_0: q=%h r=%0d z=%b, required ff 5 1", q, r, z);
    end
    take_result();
    run_op(8'd9, 8'd3, lat, q, r, z);
    vectors++;
    if (q !== 8'd3 || r !== 8'd0 || z !== 1'b0 || lat !== 8) begin
      miscompares++;
      $display("FAIL dbz_followup_9_3: q=%0d r=%0d z=%b lat=%0d, required 3 0 0 8", q, r, z, lat);
    end
    take_result();
  endtask

  task automatic test_backpressure();
    int lat; logic [W-1:0] q, r; logic z;
    int bad = 0;
    run_op(8'd50, 8'd6, lat, q, r, z);
    vectors++;
    if (q !== 8'd8 || r !== 8'd2 || z !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_50_6: q=%0d r=%0d z=%b, required 8 2 0", q, r, z);
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_valid = (c == 3);
      dividend = 8'd77;
      divisor  = 8'd0;
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== 8'd8 ||
          remainder !== 8'd2 || div_by_zero !== 1'b0) bad++;
    end
    in_valid = 1'b0;
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL bp_hold: %0d unstable cycles, required 0", bad);
    end
    take_result();
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || quotient !== 8'd8 || div_by_zero !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b q=%0d z=%b, required 0 1 8 0",
               out_valid, in_ready, quotient, div_by_zero);
    end
  endtask

  task automatic test_reset_mid_calc();
    int stale = 0;
    int lat; logic [W-1:0] q, r; logic z;
    @(negedge clk);
    dividend = 8'd100;
    divisor  = 8'd7;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || quotient !== 8'd0 ||
        remainder !== 8'd0 || div_by_zero !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_state: in_ready=%b out_valid=%b q=%h r=%h z=%b, required 1 0 00 00 0",
               in_ready, out_valid, quotient, remainder, div_by_zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || quotient !== 8'd0) stale++;
    end
    vectors++;
    if (stale !== 0) begin
      miscompares++;
      $display("FAIL midreset_stale: %0d cycles with stale result, required 0", stale);
    end
    run_op(8'd9, 8'd4, lat, q, r, z);
    vectors++;
    if (q !== 8'd2 || r !== 8'd1 || lat !== 8) begin
      miscompares++;
      $display("FAIL midreset_recover_9_4: q=%0d r=%0d lat=%0d, required 2 1 8", q, r, lat);
    end
    take_result();
  endtask

  task automatic test_back_to_back();
    int lat; logic [W-1:0] q, r; logic z;
    run_op(8'd143, 8'd11, lat, q, r, z);
    vectors++;
    if (q !== 8'd13 || r !== 8'd0 || lat !== 8) begin
      miscompares++;
      $display("FAIL b2b_143_11: q=%0d r=%0d lat=%0d, required 13 0 8", q, r, lat);
    end
    take_result();
    run_op(8'd17, 8'd5, lat, q, r, z);
    vectors++;
    if (q !== 8'd3 || r !== 8'd2 || lat !== 8) begin
      miscompares++;
      $display("FAIL b2b_17_5: q=%0d r=%0d lat=%0d, required 3 2 8", q, r, lat);
    end
    take_result();
  endtask

`ifdef SEQ_DIVIDER_SIGNED_EN
  task automatic test_signed();
    logic [W-1:0] va [4] = '{8'hF9, 8'h07, 8'h80, 8'hF9};
    logic [W-1:0] vb [4] = '{8'h02, 8'hFE, 8'hFF, 8'h00};
    logic [W-1:0] eq [4] = '{8'hFD, 8'hFD, 8'h80, 8'hFF};
    logic [W-1:0] er [4] = '{8'hFF, 8'h01, 8'h00, 8'hF9};
    logic         ez [4] = '{1'b0,  1'b0,  1'b0,  1'b1};
    for (int i = 0; i < 4; i++) begin
      int lat; logic [W-1:0] q, r; logic z;
      run_op(va[i], vb[i], lat, q, r, z);
      vectors++;
      if (q !== eq[i] || r !== er[i] || z !== ez[i]) begin
        miscompares++;
        $display("FAIL signed_%h_%h: q=%h r=%h z=%b, required %h %h %b",
                 va[i], vb[i], q, r, z, eq[i], er[i], ez[i]);
      end
      take_result();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_div_zero();
    test_backpressure();
    test_reset_mid_calc();
    test_back_to_back();
`ifdef SEQ_DIVIDER_SIGNED_EN
    test_signed();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
